// File: rtl/food_gen.sv
// Food generator for the snake game: draws a new pseudo-random grid cell after each
// eat pulse, renders the food square for the pixel stream and keeps the eaten-food count.
module food_gen #(
  parameter logic [15:0] SEED    = 16'hACE1,
  parameter logic [5:0]  INIT_CX = 6'd24,
  parameter logic [5:0]  INIT_CY = 6'd10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       drive,
  input  logic [9:0] x_pos,
  input  logic [9:0] y_pos,
  output logic [9:0] box_x,
  output logic [9:0] box_y,
  output logic       box_r,
  output logic [7:0] eat_cnt,
  output logic       busy
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] DRAW_X = 3'd1;
  localparam logic [2:0] DRAW_Y = 3'd2;
  localparam logic [2:0] LOAD   = 3'd3;
  localparam logic [2:0] COOL   = 3'd4;

  // Cell origin 12 + 18*c built from shifts; max 588 so 10 bits never wrap.
  function automatic logic [9:0] origin(input logic [5:0] c);
    logic [9:0] cw;
    cw = {4'd0, c};
    return 10'd12 + (cw << 4) + (cw << 1);
  endfunction

  logic [2:0]  state;
  logic [2:0]  state_nx;
  logic [15:0] lfsr;
  logic [15:0] lfsr_nx;
  logic [5:0]  cur_cx;
  logic [5:0]  cur_cy;
  logic [5:0]  new_cx;
  logic [5:0]  new_cy;
  logic [5:0]  cand_x;
  logic [5:0]  cand_y;
  logic        x_ok;
  logic        y_ok;

  assign lfsr_nx = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
  assign cand_x  = lfsr[5:0];
  assign cand_y  = lfsr[13:8];
  assign x_ok    = (cand_x < 6'd33);
  assign y_ok    = (cand_y < 6'd33);

  // Next-state logic; a redraw that lands on the displayed cell restarts from the column draw.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (drive) state_nx = DRAW_X;
        else       state_nx = IDLE;
      end
      DRAW_X: begin
        if (x_ok) state_nx = DRAW_Y;
        else      state_nx = DRAW_X;
      end
      DRAW_Y: begin
        if (!y_ok)                                      state_nx = DRAW_Y;
        else if ((new_cx == cur_cx) && (cand_y == cur_cy)) state_nx = DRAW_X;
        else                                            state_nx = LOAD;
      end
      LOAD:    state_nx = COOL;
      COOL:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State, free-running LFSR, candidate/current cell, box origins and score.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      lfsr    <= SEED;
      cur_cx  <= INIT_CX;
      cur_cy  <= INIT_CY;
      new_cx  <= 6'd0;
      new_cy  <= 6'd0;
      box_x   <= origin(INIT_CX);
      box_y   <= origin(INIT_CY);
      eat_cnt <= 8'd0;
      busy    <= 1'b0;
    end else begin
      state <= state_nx;
      lfsr  <= lfsr_nx;
      busy  <= (state_nx != IDLE);
      if ((state == IDLE) && drive && (eat_cnt != 8'hFF)) begin
        eat_cnt <= eat_cnt + 8'd1;
      end
      if ((state == DRAW_X) && x_ok) begin
        new_cx <= cand_x;
      end
      if ((state == DRAW_Y) && (state_nx == LOAD)) begin
        new_cy <= cand_y;
      end
      if (state == LOAD) begin
        cur_cx <= new_cx;
        cur_cy <= new_cy;
        box_x  <= origin(new_cx);
        box_y  <= origin(new_cy);
      end
    end
  end

  assign box_r = (x_pos >= box_x + 10'd3) && (x_pos <= box_x + 10'd15) &&
                 (y_pos >= box_y + 10'd3) && (y_pos <= box_y + 10'd15);

endmodule

// File: tb/tb_food_gen.sv
// Randomized self-checking bench for food_gen against a behavioural model of the
// generation sequence (phase counter, integer LFSR and arithmetic grid origins).
module tb_food_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       drive;
  logic [9:0] x_pos;
  logic [9:0] y_pos;
  logic [9:0] box_x;
  logic [9:0] box_y;
  logic       box_r;
  logic [7:0] eat_cnt;
  logic       busy;

  food_gen dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .drive   (drive),
    .x_pos   (x_pos),
    .y_pos   (y_pos),
    .box_x   (box_x),
    .box_y   (box_y),
    .box_r   (box_r),
    .eat_cnt (eat_cnt),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Model: phase 0 idle, 1 column draw, 2 row draw, 3 load, 4 cool-down.
  int m_phase, m_lfsr, m_cx, m_cy, m_ncx, m_ncy, m_cnt;
  int prev_bx = 444;
  int prev_by = 192;

  function automatic int lfsr_next(input int v);
    int fb;
    fb = ((v >> 0) ^ (v >> 2) ^ (v >> 3) ^ (v >> 5)) & 1;
    return ((v >> 1) | (fb << 15)) & 16'hFFFF;
  endfunction

  function automatic int cell_origin(input int c);
    return 12 + 18 * c;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_lfsr = 16'hACE1; m_cx = 24; m_cy = 10;
    m_ncx = 0; m_ncy = 0; m_cnt = 0;
  endtask

  task automatic model_step(input bit d);
    int lx, ly;
    lx = m_lfsr & 63;
    ly = (m_lfsr >> 8) & 63;
    case (m_phase)
      0: if (d) begin m_phase = 1; if (m_cnt < 255) m_cnt++; end
      1: if (lx < 33) begin m_ncx = lx; m_phase = 2; end
      2: if (ly < 33) begin
           if (m_ncx == m_cx && ly == m_cy) m_phase = 1;
           else begin m_ncy = ly; m_phase = 3; end
         end
      3: begin m_cx = m_ncx; m_cy = m_ncy; m_phase = 4; end
      default: m_phase = 0;
    endcase
    m_lfsr = lfsr_next(m_lfsr);
  endtask

  task automatic step(input bit d);
    drive = d;
    if ($urandom_range(0, 1) == 0) begin
      x_pos = 10'(cell_origin(m_cx) + $urandom_range(0, 18));
      y_pos = 10'(cell_origin(m_cy) + $urandom_range(0, 18));
    end else begin
      x_pos = 10'($urandom_range(0, 1023));
      y_pos = 10'($urandom_range(0, 1023));
    end
    @(posedge clk);
    if (rst_n) model_step(d);
    #1;
  endtask

  task automatic first_gen();
    int n;
    repeat (3) step(1'b0);
    step(1'b1);
    n = 0;
    while (m_phase != 0 && n < 200) begin step(1'b0); n++; end
    check("gen_timeout", int'(m_phase == 0), 1);
  endtask

  // Per-cycle comparison of every output against the model, plus grid property on moves.
  always @(negedge clk) begin
    int bx, by, exp_r;
    if (cmp_en) begin
      bx = cell_origin(m_cx);
      by = cell_origin(m_cy);
      exp_r = (int'(x_pos) >= bx + 3 && int'(x_pos) <= bx + 15 &&
               int'(y_pos) >= by + 3 && int'(y_pos) <= by + 15) ? 1 : 0;
      check("box_x", int'(box_x), bx);
      check("box_y", int'(box_y), by);
      check("eat_cnt", int'(eat_cnt), m_cnt);
      check("busy", int'(busy), (m_phase != 0) ? 1 : 0);
      check("box_r", int'(box_r), exp_r);
      if (rst_n && (int'(box_x) != prev_bx || int'(box_y) != prev_by)) begin
        check("on_grid", int'(((int'(box_x) - 12) % 18 == 0) && box_x <= 10'd588 &&
                              ((int'(box_y) - 12) % 18 == 0) && box_y <= 10'd588), 1);
      end
      prev_bx = int'(box_x);
      prev_by = int'(box_y);
    end
  end

  initial begin
    int first_x, first_y, n;
    rst_n = 1'b0; drive = 1'b0; x_pos = 10'd0; y_pos = 10'd0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    cmp_en = 1'b1;

    check("lfsr_pin", lfsr_next(16'hACE1), 16'h5670);
    check("rst_box_x", int'(box_x), 444);
    check("rst_box_y", int'(box_y), 192);
    check("rst_eat", int'(eat_cnt), 0);
    check("rst_busy", int'(busy), 0);
    x_pos = 10'd447; y_pos = 10'd195; #1 check("pix_447_195", int'(box_r), 1);
    x_pos = 10'd446; y_pos = 10'd195; #1 check("pix_446_195", int'(box_r), 0);
    x_pos = 10'd459; y_pos = 10'd207; #1 check("pix_459_207", int'(box_r), 1);
    x_pos = 10'd460; y_pos = 10'd207; #1 check("pix_460_207", int'(box_r), 0);

    first_gen();
    first_x = cell_origin(m_cx);
    first_y = cell_origin(m_cy);
    check("first_eat", int'(eat_cnt), 1);
    check("first_moved", int'(box_x != 10'd444 || box_y != 10'd192), 1);

    for (int i = 0; i < 20; i++) step(i % 2 == 0);
    for (int i = 0; i < 1000; i++) step($urandom_range(0, 3) == 0);

    // Abort a generation in the row draw with an asynchronous reset.
    while (m_phase != 0) step(1'b0);
    step(1'b1);
    n = 0;
    while (m_phase != 2 && n < 100) begin step(1'b0); n++; end
    check("reach_draw_y", m_phase, 2);
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    check("mid_rst_box_x", int'(box_x), 444);
    check("mid_rst_box_y", int'(box_y), 192);
    check("mid_rst_eat", int'(eat_cnt), 0);
    check("mid_rst_busy", int'(busy), 0);
    step(1'b0);
    step(1'b0);
    rst_n = 1'b1;
    first_gen();
    check("replay_box_x", int'(box_x), first_x);
    check("replay_box_y", int'(box_y), first_y);
    check("replay_eat", int'(eat_cnt), 1);

    repeat (3000) step(1'b1);
    check("sat_eat", int'(eat_cnt), 255);
    repeat (60) step(1'b1);
    check("sat_hold", int'(eat_cnt), 255);

    @(negedge clk);
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/food_gen.md
# food_gen

Food (target box) generator for the snake game. It is the counterpart to the snake control block: it consumes the one-cycle `drive` pulse that snake control raises when the head reaches the food cell. It then picks a new pseudo-random grid cell, presents it on `box_x`/`box_y`, and renders the food square for the VGA pixel stream. It also keeps the eaten-food count for the score display.

## Interface
- `SEED`, 16'hACE1, LFSR reset value; must be non-zero.
- `INIT_CX`, 24, food column index after reset (box_x = 444).
- `INIT_CY`, 10, food row index after reset (box_y = 192).
- `clk`  in  1  system clock; the same clock as snake control.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `drive`  in  1  eat pulse from snake control; one cycle long, may repeat every other cycle.
- `x_pos`  in  10  current VGA pixel x.
- `y_pos`  in  10  current VGA pixel y.
- `box_x`  out  10  food cell x origin, registered.
- `box_y`  out  10  food cell y origin, registered.
- `box_r`  out  1  combinational; high when the pixel lies inside the food square.
- `eat_cnt`  out  8  foods eaten, registered, saturating.
- `busy`  out  1  high while the state machine is not in IDLE.

## Operation
- Grid: 33×33 cells with index c in 0..32. Origin = 12 + 18·c, so origins run 12..588.
  - Compute 18·c as (c<<4)+(c<<1) in 10 bits. No overflow is possible (max 588).
- LFSR: 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1. It is free-running and shifts every clock in every state.
- Registers:
  - cur_cx, cur_cy (6 bit): index of the displayed cell.
  - new_cx, new_cy (6 bit): candidate under construction.
- State machine, one transition per clock:
  - IDLE: if `drive`=1, go to DRAW_X and increment `eat_cnt` (hold at 255). Otherwise stay.
  - DRAW_X: if lfsr[5:0] < 33, latch new_cx = lfsr[5:0] and go to DRAW_Y. Otherwise stay.
  - DRAW_Y: if lfsr[13:8] < 33 and (new_cx, lfsr[13:8]) ≠ (cur_cx, cur_cy), latch new_cy and go to LOAD.
    - If lfsr[13:8] ≥ 33, stay.
    - If the cell equals the current cell, return to DRAW_X.
  - LOAD: cur_cx/cur_cy ← new_cx/new_cy; box_x/box_y ← origins of the new indices. Go to COOL.
  - COOL: ignore `drive` and go to IDLE.
    - Reason: snake control can issue one stale pulse computed against the old box on the LOAD edge.
- `drive` is ignored in every state except IDLE. Repeated pulses during a generation neither restart it nor change `eat_cnt`.
- `box_r` = (box_x+3 ≤ x_pos ≤ box_x+15) && (box_y+3 ≤ y_pos ≤ box_y+15).
  - Compute in 10 bits; the max sum is 603, so there is no wrap.
- `busy` = (state ≠ IDLE).

## Timing
- Reset values (asynchronous):
  - state=IDLE, lfsr=SEED.
  - cur_cx=INIT_CX, cur_cy=INIT_CY.
  - box_x=444, box_y=192.
  - eat_cnt=0, busy=0.
- Edge 0 samples `drive`=1 in IDLE. At that edge, eat_cnt updates and busy rises.
- Minimum latency: box_x/box_y change on the 3rd edge after edge 0 (DRAW_X, DRAW_Y, LOAD). busy falls on the 4th edge.
- Each rejected draw adds one cycle. The LFSR has maximal period, so generation always terminates.
- box_x and box_y change on the same edge; never one without the other.
- `drive` held high continuously in IDLE is accepted once per generation: IDLE→…→IDLE, then accepted again.
- eat_cnt at 255: `drive` still triggers a full relocation, and eat_cnt stays 255.
- Reset asserted mid-generation: all registers return to reset values immediately. A pending candidate is discarded and box stays at 444/192.

## Test plan
- Reset: release rst_n → box_x=444, box_y=192, eat_cnt=0, busy=0, box_r=1 at pixel (447,195), 0 at (446,195), 1 at (459,207), 0 at (460,207).
- Single `drive` pulse → eat_cnt=1. box updates no earlier than 3 edges later. New box_x, box_y ∈ {12+18k}, ≤588, and differ from (444,192). busy is high for ≥4 cycles.
- `drive` pulsing every other cycle for 20 cycles after the first acceptance → eat_cnt increments once per completed generation, never during busy. No box update in COOL.
- 300 separated pulses → eat_cnt saturates at 255. Every new box is on grid and differs from the previous box.
- Assert rst_n low while in DRAW_Y → box returns to 444/192, eat_cnt=0, state IDLE, LFSR=SEED. A pulse after release reproduces the post-reset sequence exactly.
- Scoreboard: model the LFSR and FSM; compare box_x/box_y/eat_cnt each cycle across 1000 random `drive` patterns.
